carfield_apb_mailbox: RTL and testbench
=======================================

Name: carfield_apb_mailbox

Overview:
- APB responder at the CarRegs/OT-mailbox peripheral end of the Carfield peripheral map.
- Host (CVA6 through the APB demux) pushes 32-bit words into a FIFO. The FIFO drains onto a valid/ready stream toward the security island.
- Drives one level interrupt, `irq_o`, back to the host: a low-watermark "space available" signal that feeds the external interrupt line.

Parameters:
- DataWidth, 32, APB data and stream width.
- Depth, 8, FIFO entries (power of two, ≥2).
- AddrWidth, 12, APB address bits decoded (4 KiB window).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- paddr_i  in  AddrWidth  APB address.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  APB write.
- pwdata_i  in  DataWidth  APB write data.
- pstrb_i  in  DataWidth/8  APB strobes; DATA accepts only all-ones.
- pready_o  out  1  APB ready.
- prdata_o  out  DataWidth  APB read data.
- pslverr_o  out  1  APB error.
- mbox_data_o  out  DataWidth  FIFO head word.
- mbox_valid_o  out  1  FIFO non-empty.
- mbox_ready_i  in  1  consumer accept.
- irq_o  out  1  level interrupt to host.

Behaviour:
- Reset values:
  - pready_o=0, prdata_o=0, pslverr_o=0, mbox_valid_o=0, irq_o=0.
  - FIFO empty; IRQ_EN=0; THRESH=0; PENDING=0.
- Register map (byte offset; paddr_i[1:0] ignored):
  - 0x00 DATA: W only; push. Read → pslverr=1, prdata=0.
  - 0x04 STATUS: R only. [0]=empty, [1]=full, [$clog2(Depth)+2:2]=count. Write → pslverr=1, ignored.
  - 0x08 IRQ_EN: RW, bit0.
  - 0x0C THRESH: RW, [$clog2(Depth):0]; upper bits read 0.
  - 0x10 IRQ_STATUS: bit0=PENDING. Read; write-1-to-clear.
  - 0x14 CTRL: W bit0=1 flushes the FIFO. Reads 0.
  - Any other offset → pslverr=1, prdata=0, no side effect.
- APB FSM, states IDLE and RESP:
  - IDLE → RESP when psel_i & penable_i. In that cycle the access is performed: write side-effect or read sample. prdata and pslverr are registered.
  - RESP: pready_o=1 for exactly one cycle, then IDLE.
  - Every access therefore has exactly one wait state; pready_o is 0 in the first access-phase cycle.
  - psel_i dropping in RESP is a protocol violation; FSM returns to IDLE regardless.
- DATA write errors:
  - Full FIFO → pslverr=1, word dropped.
  - pstrb_i ≠ all-ones → pslverr=1, no push.
- Stream side:
  - mbox_data_o is the head word; mbox_valid_o = !empty.
  - Pop on mbox_valid_o & mbox_ready_i.
  - mbox_data_o is stable while valid and not ready.
- Simultaneous push and pop:
  - Allowed in the same cycle, count unchanged.
  - When full, pop and push in the same cycle still errors the push: full is evaluated before the pop.
- Flush:
  - Count=0 the next cycle; mbox_valid_o=0 the next cycle.
  - A pop in the flush cycle is discarded. Flush wins over any same-cycle pop.
- Count arithmetic: $clog2(Depth)+1 bits, range 0..Depth. Pointers wrap modulo Depth.
- Interrupt:
  - Watermark event = THRESH≠0 & count < THRESH, evaluated on the registered count each cycle.
  - PENDING sets on the event and is sticky.
  - A W1C in the same cycle as the event leaves PENDING=1 (set wins).
  - irq_o = registered (IRQ_EN & PENDING), so it follows its inputs by one cycle.
  - Clearing IRQ_EN masks irq_o without clearing PENDING.
- Reset mid-transfer:
  - Asynchronous, clears everything immediately.
  - An in-flight APB access gets no pready; the master must restart.

Decomposition:
- carfield_pkg gains:
  - register offsets: MboxDataOffs, MboxStatusOffs, MboxIrqEnOffs, MboxThreshOffs, MboxIrqStatusOffs, MboxCtrlOffs;
  - MboxBase and MboxSize in the apb_start_t/apb_end_t style;
  - an apb_fsm_e enum {Idle, Resp}.
- Storage is one sub-module: common_cells fifo_v3 (FALL_THROUGH=0, DEPTH=Depth), whose flush_i and usage_o are used directly.
- Register decode and the interrupt logic stay in the top module.

Test Plan:
- Write DATA 0xDEAD_BEEF with mbox_ready_i=0 → pready_o high on the 2nd access cycle, pslverr_o=0. mbox_valid_o=1 and mbox_data_o=0xDEAD_BEEF the cycle after. STATUS reads 0x4 (count=1).
- Push 8 words, then a 9th → 9th gets pslverr_o=1. STATUS=0x22 (full, count=8). Drain with mbox_ready_i=1 → words appear in order, mbox_valid_o=0 after the 8th pop.
- Full FIFO, mbox_ready_i=1 held, write DATA in the same cycle as a pop → push errors, count goes 8→7.
- THRESH=4, IRQ_EN=1, FIFO at 6, drain → PENDING sets when count reads 3, irq_o high one cycle later. W1C of 0x1 while count is still 3 → PENDING stays 1. Refill to 6, then W1C → irq_o drops.
- CTRL write 0x1 with 5 entries while mbox_ready_i=1 → next cycle count=0 and mbox_valid_o=0; only the pops before the flush cycle are observed.
- Read offset 0x18, write STATUS, and write DATA with pstrb 0x7 → each returns pslverr_o=1 and prdata_o=0, with no state change. Assert rst_ni mid-access → all outputs 0 asynchronously.

Source files
------------

// File: rtl/carfield_pkg.sv
// Carfield shared definitions: APB peripheral map entry and register offsets
// for the host-to-security-island mailbox.
package carfield_pkg;

  typedef logic [31:0] apb_start_t;
  typedef logic [31:0] apb_end_t;

  localparam apb_start_t MboxBase = 32'h2000_8000;
  localparam apb_end_t   MboxSize = 32'h0000_1000;

  localparam logic [11:0] MboxDataOffs      = 12'h000;
  localparam logic [11:0] MboxStatusOffs    = 12'h004;
  localparam logic [11:0] MboxIrqEnOffs     = 12'h008;
  localparam logic [11:0] MboxThreshOffs    = 12'h00C;
  localparam logic [11:0] MboxIrqStatusOffs = 12'h010;
  localparam logic [11:0] MboxCtrlOffs      = 12'h014;

  typedef enum logic {
    Idle,
    Resp
  } apb_fsm_e;

endpackage

// File: rtl/carfield_fifo_v3.sv
// Synchronous FIFO with flush and occupancy output; DEPTH must be a power of two
// so the read/write pointers wrap naturally.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned AddrDepth   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [AddrDepth:0]    usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [AddrDepth-1:0]  rdPtr, wrPtr;
  logic [AddrDepth:0]    count;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  doPush, doPop;

  assign full_o  = (count == (AddrDepth+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign usage_o = count;

  always_comb begin
    doPush = push_i & ~full_o;
    doPop  = pop_i & ~empty_o;
    data_o = mem[rdPtr];
    // In fall-through mode a word pushed and popped while empty bypasses storage.
    if (FALL_THROUGH && empty_o) begin
      data_o = data_i;
      if (push_i && pop_i) begin
        doPush = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush_i) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AddrDepth'(1);
      if (doPop)  rdPtr <= rdPtr + AddrDepth'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AddrDepth+1)'(1);
        2'b01:   count <= count - (AddrDepth+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (doPush && !flush_i) begin
      mem[wrPtr] <= data_i;
    end
  end

endmodule

// File: rtl/carfield_apb_mailbox.sv
// APB mailbox: host pushes words into a FIFO drained toward the security island,
// with a low-watermark "space available" interrupt back to the host.
//
// state | meaning
// Idle  | waiting for an access phase (psel & penable); access performed on exit
// Resp  | pready high for one cycle with registered prdata/pslverr
module carfield_apb_mailbox
  import carfield_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 8,
  parameter int unsigned AddrWidth = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   paddr_i,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [DataWidth-1:0]   pwdata_i,
  input  logic [DataWidth/8-1:0] pstrb_i,
  output logic                   pready_o,
  output logic [DataWidth-1:0]   prdata_o,
  output logic                   pslverr_o,
  output logic [DataWidth-1:0]   mbox_data_o,
  output logic                   mbox_valid_o,
  input  logic                   mbox_ready_i,
  output logic                   irq_o
);

  localparam int unsigned CntWidth = $clog2(Depth) + 1;

  apb_fsm_e             state, stateNext;
  logic                 access;
  logic [AddrWidth-1:0] regAddr;
  logic [DataWidth-1:0] rdataNext, prdataQ;
  logic                 errNext, pslverrQ;
  logic                 irqEnQ, irqEnNext, pendingQ, irqQ, w1c, watermark;
  logic [CntWidth-1:0]  threshQ, threshNext, usage;
  logic                 fifoFull, fifoEmpty, fifoPush, fifoFlush;
  logic                 unusedAddrLsb;

  assign unusedAddrLsb = ^paddr_i[1:0];
  assign regAddr       = {paddr_i[AddrWidth-1:2], 2'b00};

  fifo_v3 #(
    .FALL_THROUGH(1'b0),
    .DATA_WIDTH  (DataWidth),
    .DEPTH       (Depth)
  ) i_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(fifoFlush),
    .full_o (fifoFull),
    .empty_o(fifoEmpty),
    .usage_o(usage),
    .data_i (pwdata_i),
    .push_i (fifoPush),
    .data_o (mbox_data_o),
    .pop_i  (mbox_ready_i)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= Idle;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    access    = 1'b0;
    case (state)
      Idle: begin
        if (psel_i && penable_i) begin
          access    = 1'b1;
          stateNext = Resp;
        end
      end
      Resp:    stateNext = Idle;
      default: stateNext = Idle;
    endcase
  end

  always_comb begin
    rdataNext  = '0;
    errNext    = 1'b0;
    fifoPush   = 1'b0;
    fifoFlush  = 1'b0;
    w1c        = 1'b0;
    irqEnNext  = irqEnQ;
    threshNext = threshQ;
    if (access) begin
      case (regAddr)
        AddrWidth'(MboxDataOffs): begin
          // Full is judged before any same-cycle pop, so a push to a full FIFO always errors.
          if (!pwrite_i || pstrb_i != '1 || fifoFull) errNext = 1'b1;
          else                                        fifoPush = 1'b1;
        end
        AddrWidth'(MboxStatusOffs): begin
          if (pwrite_i) begin
            errNext = 1'b1;
          end else begin
            rdataNext[0]            = fifoEmpty;
            rdataNext[1]            = fifoFull;
            rdataNext[CntWidth+1:2] = usage;
          end
        end
        AddrWidth'(MboxIrqEnOffs): begin
          if (pwrite_i) irqEnNext = pwdata_i[0];
          else          rdataNext[0] = irqEnQ;
        end
        AddrWidth'(MboxThreshOffs): begin
          if (pwrite_i) threshNext = pwdata_i[CntWidth-1:0];
          else          rdataNext[CntWidth-1:0] = threshQ;
        end
        AddrWidth'(MboxIrqStatusOffs): begin
          if (pwrite_i) w1c = pwdata_i[0];
          else          rdataNext[0] = pendingQ;
        end
        AddrWidth'(MboxCtrlOffs): begin
          if (pwrite_i) fifoFlush = pwdata_i[0];
        end
        default: errNext = 1'b1;
      endcase
    end
  end

  assign watermark = (threshQ != '0) && (usage < threshQ);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prdataQ  <= '0;
      pslverrQ <= 1'b0;
      irqEnQ   <= 1'b0;
      threshQ  <= '0;
      pendingQ <= 1'b0;
      irqQ     <= 1'b0;
    end else begin
      prdataQ  <= rdataNext;
      pslverrQ <= errNext;
      irqEnQ   <= irqEnNext;
      threshQ  <= threshNext;
      // A new watermark event outranks a same-cycle clear.
      pendingQ <= watermark | (pendingQ & ~w1c);
      irqQ     <= irqEnQ & pendingQ;
    end
  end

  assign pready_o     = (state == Resp);
  assign prdata_o     = prdataQ;
  assign pslverr_o    = pslverrQ;
  assign mbox_valid_o = ~fifoEmpty;
  assign irq_o        = irqQ;

endmodule

// File: tb/tb_carfield_apb_mailbox.sv
// Directed self-checking bench for the APB mailbox: register access, FIFO
// ordering, overflow, flush, watermark interrupt and asynchronous reset.
module tb_carfield_apb_mailbox;
  import carfield_pkg::*;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [11:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [31:0] mboxData;
  logic        mboxValid, mboxReady, irq;

  int total = 0;
  int bad = 0;
  logic [31:0] rd;
  logic        er;

  carfield_apb_mailbox dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .paddr_i     (paddr),
    .psel_i      (psel),
    .penable_i   (penable),
    .pwrite_i    (pwrite),
    .pwdata_i    (pwdata),
    .pstrb_i     (pstrb),
    .pready_o    (pready),
    .prdata_o    (prdata),
    .pslverr_o   (pslverr),
    .mbox_data_o (mboxData),
    .mbox_valid_o(mboxValid),
    .mbox_ready_i(mboxReady),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // readyMode: 0 = consumer idle, 1 = ready on the access edge only,
  // 2 = ready on both setup and access edges.
  task automatic apbAccess(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int readyMode,
                           output logic [31:0] rdata, output logic err);
    int waitCnt;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    if (readyMode == 2) mboxReady = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    if (readyMode == 1) mboxReady = 1'b1;
    chk("pready_first_access_cycle", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;
    if (readyMode != 0) mboxReady = 1'b0;
    waitCnt = 0;
    while (pready !== 1'b1 && waitCnt < 4) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    chk("one_wait_state", waitCnt, 0);
    rdata = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic pushWord(input logic [31:0] d);
    logic [31:0] r;
    logic e;
    apbAccess(1'b1, MboxDataOffs, d, 4'hF, 0, r, e);
    chk("push_err", {31'd0, e}, 32'd0);
  endtask

  initial begin
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0; mboxReady = 0;
    #1;
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst_valid", {31'd0, mboxValid}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    @(posedge clk); #1;

    // Single push, then status and drain.
    apbAccess(1'b1, MboxDataOffs, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
    chk("t1_err", {31'd0, er}, 32'd0);
    chk("t1_valid", {31'd0, mboxValid}, 32'd1);
    chk("t1_data", mboxData, 32'hDEAD_BEEF);
    apbAccess(1'b0, MboxStatusOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t1_status", rd, 32'h4);
    chk("t1_status_err", {31'd0, er}, 32'd0);
    mboxReady = 1'b1;
    @(posedge clk); #1;
    mboxReady = 1'b0;
    chk("t1_drained", {31'd0, mboxValid}, 32'd0);

    // Fill, overflow, in-order drain.
    for (int i = 0; i < 8; i++) pushWord(32'h100 + i);
    apbAccess(1'b1, MboxDataOffs, 32'h1FF, 4'hF, 0, rd, er);
    chk("t2_overflow_err", {31'd0, er}, 32'd1);
    apbAccess(1'b0, MboxStatusOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t2_status_full", rd, 32'h22);
    mboxReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_valid", {31'd0, mboxValid}, 32'd1);
      chk("t2_order", mboxData, 32'h100 + i);
      @(posedge clk); #1;
    end
    mboxReady = 1'b0;
    chk("t2_empty", {31'd0, mboxValid}, 32'd0);

    // Push into a full FIFO in the same cycle as a pop.
    for (int i = 0; i < 8; i++) pushWord(32'h200 + i);
    apbAccess(1'b1, MboxDataOffs, 32'h2FF, 4'hF, 1, rd, er);
    chk("t3_push_pop_full_err", {31'd0, er}, 32'd1);
    apbAccess(1'b0, MboxStatusOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t3_status_7", rd, 32'h1C);
    chk("t3_head", mboxData, 32'h201);
    apbAccess(1'b1, MboxCtrlOffs, 32'd1, 4'hF, 0, rd, er);
    apbAccess(1'b0, MboxStatusOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t3_flushed", rd, 32'h1);

    // Watermark interrupt.
    for (int i = 0; i < 6; i++) pushWord(32'h400 + i);
    apbAccess(1'b1, MboxThreshOffs, 32'd4, 4'hF, 0, rd, er);
    apbAccess(1'b1, MboxIrqEnOffs, 32'd1, 4'hF, 0, rd, er);
    apbAccess(1'b0, MboxIrqStatusOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t4_pending_idle", rd, 32'd0);
    chk("t4_irq_idle", {31'd0, irq}, 32'd0);
    mboxReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 mboxReady = 1'b0;
    chk("t4_irq_count3", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("t4_irq_pending_cycle", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("t4_irq_high", {31'd0, irq}, 32'd1);
    apbAccess(1'b0, MboxStatusOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t4_status_3", rd, 32'hC);
    apbAccess(1'b1, MboxIrqStatusOffs, 32'd1, 4'hF, 0, rd, er);
    apbAccess(1'b0, MboxIrqStatusOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t4_w1c_set_wins", rd, 32'd1);
    for (int i = 0; i < 3; i++) pushWord(32'h410 + i);
    apbAccess(1'b0, MboxStatusOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t4_status_6", rd, 32'h18);
    apbAccess(1'b1, MboxIrqStatusOffs, 32'd1, 4'hF, 0, rd, er);
    chk("t4_irq_cleared", {31'd0, irq}, 32'd0);
    apbAccess(1'b0, MboxIrqStatusOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t4_pending_cleared", rd, 32'd0);
    apbAccess(1'b1, MboxIrqEnOffs, 32'd0, 4'hF, 0, rd, er);
    apbAccess(1'b1, MboxThreshOffs, 32'd0, 4'hF, 0, rd, er);
    apbAccess(1'b1, MboxCtrlOffs, 32'd1, 4'hF, 0, rd, er);

    // Flush while the consumer is popping.
    for (int i = 0; i < 5; i++) pushWord(32'h300 + i);
    apbAccess(1'b0, MboxStatusOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t5_status_5", rd, 32'h14);
    apbAccess(1'b1, MboxCtrlOffs, 32'd1, 4'hF, 2, rd, er);
    chk("t5_flush_err", {31'd0, er}, 32'd0);
    chk("t5_valid_after_flush", {31'd0, mboxValid}, 32'd0);
    apbAccess(1'b0, MboxStatusOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t5_status_empty", rd, 32'h1);
    pushWord(32'h3AA);
    chk("t5_head_after_flush", mboxData, 32'h3AA);
    apbAccess(1'b1, MboxCtrlOffs, 32'd1, 4'hF, 0, rd, er);

    // Error responses with no side effect.
    apbAccess(1'b0, 12'h018, 32'd0, 4'hF, 0, rd, er);
    chk("t6_bad_offs_err", {31'd0, er}, 32'd1);
    chk("t6_bad_offs_rdata", rd, 32'd0);
    apbAccess(1'b1, MboxStatusOffs, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    chk("t6_status_wr_err", {31'd0, er}, 32'd1);
    apbAccess(1'b1, MboxDataOffs, 32'h5555_5555, 4'h7, 0, rd, er);
    chk("t6_strb_err", {31'd0, er}, 32'd1);
    chk("t6_strb_rdata", rd, 32'd0);
    apbAccess(1'b0, MboxStatusOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t6_status_unchanged", rd, 32'h1);
    apbAccess(1'b0, MboxDataOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t6_data_rd_err", {31'd0, er}, 32'd1);
    chk("t6_data_rd_rdata", rd, 32'd0);
    apbAccess(1'b0, MboxCtrlOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t6_ctrl_rd", rd, 32'd0);
    chk("t6_ctrl_rd_err", {31'd0, er}, 32'd0);
    apbAccess(1'b1, MboxThreshOffs, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    apbAccess(1'b0, MboxThreshOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t6_thresh_width", rd, 32'hF);

    // Asynchronous reset in the middle of a read response.
    apbAccess(1'b1, MboxIrqEnOffs, 32'd1, 4'hF, 0, rd, er);
    pushWord(32'h7777);
    chk("t7_irq_before", {31'd0, irq}, 32'd1);
    psel = 1'b1; pwrite = 1'b0; paddr = MboxStatusOffs; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("t7_pready_before", {31'd0, pready}, 32'd1);
    chk("t7_prdata_before", prdata, 32'h4);
    #2 rstN = 1'b0;
    #1;
    chk("t7_rst_pready", {31'd0, pready}, 32'd0);
    chk("t7_rst_prdata", prdata, 32'd0);
    chk("t7_rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("t7_rst_valid", {31'd0, mboxValid}, 32'd0);
    chk("t7_rst_irq", {31'd0, irq}, 32'd0);
    chk("t7_rst_data", mboxData, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    apbAccess(1'b0, MboxStatusOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t7_status_after", rd, 32'h1);
    apbAccess(1'b0, MboxIrqEnOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t7_irqen_after", rd, 32'd0);
    apbAccess(1'b0, MboxThreshOffs, 32'd0, 4'hF, 0, rd, er);
    chk("t7_thresh_after", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
